// File: rtl/img_pkg.sv
// Image-pipeline constants shared by the blur stages.
package img_pkg;
    localparam int PIX_W = 8;
    localparam int IMG_W = 512;
    localparam int IMG_H = 512;

    typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with explicit occupancy counter
// and a sticky flag for writes dropped while full.
module sync_fifo
    import img_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       rd_fire,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              wr_en;

    assign full     = (count == CNT_W'(DEPTH));
    assign rd_valid = (count != '0);
    assign rd_fire  = rd_valid && rd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en    = wr_valid && (!full || rd_fire);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !rd_fire) begin
                count <= count + CNT_W'(1);
            end else if (rd_fire && !wr_en) begin
                count <= count - CNT_W'(1);
            end
            if (wr_valid && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/blur_output_buffer.sv
// Output stage after the 3x3 blur: buffers pixels for the sink and reports
// line/frame completion as pixels are drained.
module blur_output_buffer
    import img_pkg::*;
#(
    parameter int DATA_W      = PIX_W,
    parameter int DEPTH       = 32,
    parameter int ALMOST_FULL = 24,
    parameter int LINE_W      = IMG_W,
    parameter int NUM_LINES   = IMG_H
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [DATA_W-1:0]          i_pixel_data,
    input  logic                       i_pixel_data_valid,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_data_valid,
    input  logic                       i_data_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_almost_full,
    output logic                       o_overflow,
    output logic                       o_line_done,
    output logic                       o_frame_done
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PX_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int LN_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    logic            xfer;
    logic [PX_W-1:0] px_cnt;
    logic [LN_W-1:0] line_cnt;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .wr_valid (i_pixel_data_valid),
        .wr_data  (i_pixel_data),
        .rd_ready (i_data_ready),
        .rd_data  (o_data),
        .rd_valid (o_data_valid),
        .rd_fire  (xfer),
        .count    (o_count),
        .overflow (o_overflow)
    );

    // Compare on the registered count, so this tracks o_count edge for edge.
    assign o_almost_full = (o_count >= CNT_W'(ALMOST_FULL));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            px_cnt       <= '0;
            line_cnt     <= '0;
            o_line_done  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_line_done  <= 1'b0;
            o_frame_done <= 1'b0;
            if (xfer) begin
                if (px_cnt == PX_W'(LINE_W - 1)) begin
                    px_cnt      <= '0;
                    o_line_done <= 1'b1;
                    if (line_cnt == LN_W'(NUM_LINES - 1)) begin
                        line_cnt     <= '0;
                        o_frame_done <= 1'b1;
                    end else begin
                        line_cnt <= line_cnt + LN_W'(1);
                    end
                end else begin
                    px_cnt <= px_cnt + PX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_blur_output_buffer.sv
// Randomized bench for blur_output_buffer, checked against a queue-based
// model of the FIFO and a running transfer total for line/frame pulses.
module tb_blur_output_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AF    = 24;
    localparam int LW    = 4;
    localparam int NL    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pix = '0;
    logic          pix_valid = 1'b0;
    logic          ready = 1'b0;
    logic [DW-1:0] data;
    logic          data_valid;
    logic [5:0]    count;
    logic          almost_full;
    logic          overflow;
    logic          line_done;
    logic          frame_done;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    bit            exp_ovf;
    int            exp_xfers;
    bit            exp_line;
    bit            exp_frame;

    blur_output_buffer #(
        .DATA_W(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .LINE_W(LW), .NUM_LINES(NL)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (pix_valid),
        .o_data             (data),
        .o_data_valid       (data_valid),
        .i_data_ready       (ready),
        .o_count            (count),
        .o_almost_full      (almost_full),
        .o_overflow         (overflow),
        .o_line_done        (line_done),
        .o_frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        exp_ovf   = 0;
        exp_xfers = 0;
        exp_line  = 0;
        exp_frame = 0;
    endtask

    // Drive one cycle from a negedge and advance the model past the posedge.
    task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input bit r);
        bit rd, wr;
        pix_valid = v;
        pix       = d;
        ready     = r;
        rd = (exp_q.size() > 0) && r;
        wr = v && ((exp_q.size() < DEPTH) || rd);
        if (v && !wr) exp_ovf = 1;
        exp_line  = 0;
        exp_frame = 0;
        if (rd) begin
            void'(exp_q.pop_front());
            exp_xfers++;
            if (exp_xfers % LW == 0) exp_line = 1;
            if (exp_xfers % (LW * NL) == 0) exp_frame = 1;
        end
        if (wr) exp_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        pix_valid = 0;
        ready     = 0;
        rst_n     = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({data_valid, count, almost_full, overflow, line_done, frame_done, data} !== '0) begin
            failures++;
            $display("FAIL reset_initial outputs=%h required 0",
                     {data_valid, count, almost_full, overflow, line_done, frame_done, data});
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive_cycle(1, DW'($urandom), 0);
        checks++;
        if (count !== 6'(exp_q.size()) || data !== exp_q[0]) begin
            failures++;
            $display("FAIL reset_pre_traffic count=%0d data=%h required %0d %h",
                     count, data, exp_q.size(), exp_q[0]);
        end
        #1 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if ({data_valid, count, almost_full, overflow, line_done, frame_done, data} !== '0) begin
            failures++;
            $display("FAIL reset_async outputs=%h required 0",
                     {data_valid, count, almost_full, overflow, line_done, frame_done, data});
        end
        pix_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release data_valid=%b required 0", data_valid);
        end
    endtask

    task automatic test_pass_through();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1, 8'h10 + DW'(i), 1);
            checks++;
            if (data_valid !== 1'b1 || data !== 8'h10 + DW'(i) || count > 6'd1
                || count !== 6'(exp_q.size())) begin
                failures++;
                $display("FAIL pass_through i=%0d valid=%b data=%h count=%0d required 1 %h %0d",
                         i, data_valid, data, count, 8'h10 + i, exp_q.size());
            end
        end
        drive_cycle(0, '0, 1);
        checks++;
        if (data_valid !== 1'b0 || count !== 6'd0) begin
            failures++;
            $display("FAIL pass_through_drain valid=%b count=%0d required 0 0", data_valid, count);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1, DW'($urandom), 0);
            checks++;
            if (count !== 6'((i + 1 > DEPTH) ? DEPTH : i + 1)
                || almost_full !== ((i + 1) >= AF)
                || overflow !== ((i + 1) > DEPTH)
                || overflow !== exp_ovf) begin
                failures++;
                $display("FAIL fill write=%0d count=%0d af=%b ovf=%b required %0d %b %b",
                         i + 1, count, almost_full, overflow,
                         (i + 1 > DEPTH) ? DEPTH : i + 1, (i + 1) >= AF, (i + 1) > DEPTH);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (data_valid !== 1'b1 || data !== exp_q[0]) begin
                failures++;
                $display("FAIL fill_drain i=%0d valid=%b data=%h required 1 %h",
                         i, data_valid, data, exp_q[0]);
            end
            drive_cycle(0, '0, 1);
        end
        checks++;
        if (data_valid !== 1'b0 || count !== 6'd0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL fill_empty valid=%b count=%0d ovf=%b required 0 0 1",
                     data_valid, count, overflow);
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1, DW'($urandom), 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (data !== exp_q[0]) begin
                failures++;
                $display("FAIL full_rw_head i=%0d data=%h required %h", i, data, exp_q[0]);
            end
            drive_cycle(1, DW'($urandom), 1);
            checks++;
            if (count !== 6'(DEPTH) || overflow !== 1'b0) begin
                failures++;
                $display("FAIL full_rw i=%0d count=%0d ovf=%b required %0d 0",
                         i, count, overflow, DEPTH);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (data_valid !== 1'b1 || data !== exp_q[0]) begin
                failures++;
                $display("FAIL full_rw_drain i=%0d valid=%b data=%h required 1 %h",
                         i, data_valid, data, exp_q[0]);
            end
            drive_cycle(0, '0, 1);
        end
    endtask

    task automatic test_line_frame();
        int lines, frames, cyc;
        lines = 0; frames = 0; cyc = 0;
        do_reset();
        for (int i = 0; i < 16; i++) drive_cycle(1, DW'($urandom), 0);
        while (exp_xfers < 16 && cyc < 400) begin
            drive_cycle(0, '0, ($urandom_range(0, 2) != 0));
            cyc++;
            if (line_done) lines++;
            if (frame_done) frames++;
            checks++;
            if (line_done !== exp_line || frame_done !== exp_frame) begin
                failures++;
                $display("FAIL line_frame xfers=%0d line=%b frame=%b required %b %b",
                         exp_xfers, line_done, frame_done, exp_line, exp_frame);
            end
        end
        checks++;
        if (exp_xfers != 16 || lines != 4 || frames != 1) begin
            failures++;
            $display("FAIL line_frame_totals xfers=%0d lines=%0d frames=%0d required 16 4 1",
                     exp_xfers, lines, frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lines;
        lines = 0;
        do_reset();
        for (int i = 0; i < 10; i++) drive_cycle(1, DW'($urandom), 0);
        for (int i = 0; i < 6; i++) drive_cycle(0, '0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1, DW'($urandom), 0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, '0, 1);
            if (line_done) lines++;
            checks++;
            if (line_done !== (i == 3) || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_frame xfer=%0d line=%b frame=%b required %b 0",
                         i + 1, line_done, frame_done, i == 3);
            end
        end
        checks++;
        if (lines != 1) begin
            failures++;
            $display("FAIL reset_mid_frame_total lines=%0d required 1", lines);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pass_through();
        test_fill_overflow();
        test_full_rw();
        test_line_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/blur_output_buffer.md
# blur_output_buffer

Elastic output stage directly downstream of the 3x3 blur convolution. It accepts one 8-bit convolved pixel per cycle from `conv` (valid only, no back-pressure) and stores it in a synchronous FIFO. It presents pixels to the sink (DMA or file writer) over a valid/ready handshake and counts drained pixels, emitting line-done and frame-done pulses. The host uses these pulses to pace the next line of input into the line buffers.

## Interface
Parameters:
- `DATA_W`, 8, pixel width.
- `DEPTH`, 32, FIFO entries; power of two, at least 4.
- `ALMOST_FULL`, 24, occupancy at or above which `o_almost_full` asserts; must be less than `DEPTH`.
- `LINE_W`, 512, pixels per line.
- `NUM_LINES`, 512, lines per frame.

Ports:
- `i_clk`, in, 1: sole clock, rising edge.
- `i_reset_n`, in, 1: asynchronous, active-low reset.
- `i_pixel_data`, in, `DATA_W`: convolved pixel from `conv`.
- `i_pixel_data_valid`, in, 1: write strobe.
- `o_data`, out, `DATA_W`: head-of-FIFO pixel.
- `o_data_valid`, out, 1: FIFO non-empty.
- `i_data_ready`, in, 1: sink accepts `o_data` this cycle.
- `o_count`, out, clog2(`DEPTH`)+1: current occupancy.
- `o_almost_full`, out, 1: `o_count` is at or above `ALMOST_FULL`.
- `o_overflow`, out, 1: sticky; a write was dropped.
- `o_line_done`, out, 1: one-cycle pulse per `LINE_W` pixels drained.
- `o_frame_done`, out, 1: one-cycle pulse per `LINE_W`×`NUM_LINES` pixels drained.

## Operation
- Write: occurs when `i_pixel_data_valid` is high and the FIFO is not full, or when it is full and a read happens in the same cycle.
- Write when full with no read: the pixel is dropped, pointers do not change, and `o_overflow` is set. `o_overflow` clears only on reset.
- Read (transfer): `o_data_valid && i_data_ready`. When empty, `i_data_ready` is ignored.
- Output is first-word-fall-through. `o_data` always shows the entry at the read pointer and is held stable while valid and not ready.
- Pointers are clog2(`DEPTH`) bits wide and wrap naturally. Occupancy is kept as an explicit counter.
- Simultaneous read and write leave `o_count` unchanged, including at empty→write (count 0 stays 0 only if no read, which is impossible when empty) and at full.
- Pixel counter `px_cnt` runs 0..`LINE_W`-1 and increments per transfer. On a transfer at `LINE_W`-1 it wraps to 0 and increments `line_cnt`.
- Line counter `line_cnt` runs 0..`NUM_LINES`-1. When it wraps, the frame is done.
- Counters have no state machine beyond these two; idle is the natural hold when there are no transfers.

## Timing
- Reset (asynchronous assert; deassert sampled on `i_clk`) clears pointers, count, `px_cnt`, `line_cnt`, and all flags.
- Output values during reset:
  - `o_data_valid` = 0, `o_count` = 0, `o_almost_full` = 0, `o_overflow` = 0, `o_line_done` = 0, `o_frame_done` = 0.
  - `o_data` = 0, because storage is cleared.
- Write-to-output latency is 1 cycle: a write at edge N gives `o_data_valid` = 1 after edge N.
- `o_count`, `o_almost_full`, and `o_overflow` are registered and update at the same edge as the pointer change.
- `o_line_done` is registered and high for the cycle after the edge that completes the `LINE_W`-th transfer.
- `o_frame_done` pulses in the same cycle as the final `o_line_done` of the frame.
- Reset mid-frame discards FIFO contents and counters with no pulses emitted. The next transfer counts as pixel 0 of line 0.

## Structure
- Shared package `img_pkg` holds:
  - `PIX_W` = 8, `IMG_W` = 512, `IMG_H` = 512, used as parameter defaults.
  - A typedef for the pixel type.
- Sub-module `sync_fifo` holds storage, pointers, count, full/empty, and overflow. The top adds the almost-full compare and the line/frame counters.

## Test plan
- Reset values: assert `i_reset_n` = 0 mid-traffic → all outputs 0 at once, before any clock edge. After release, `o_data_valid` = 0.
- Pass-through: write 0x10..0x1F with `i_data_ready` = 1 → same sequence out, each one cycle after its write, and `o_count` never exceeds 1.
- Fill and overflow: `i_data_ready` = 0 while writing 40 pixels.
  - `o_almost_full` rises on the cycle `o_count` reaches 24.
  - `o_count` saturates at 32 and `o_overflow` sets on write 33.
  - Draining yields exactly the first 32 values.
- Full with simultaneous read/write: hold the FIFO at 32, then assert valid and ready together for 10 cycles → `o_count` stays 32, no overflow, order is preserved.
- Line/frame pulses: use `LINE_W` = 4, `NUM_LINES` = 3, and drain 12 pixels with random ready gaps.
  - `o_line_done` pulses after transfers 4, 8, and 12.
  - `o_frame_done` pulses only with the third.
  - Counters wrap, so transfer 16 gives the next line pulse.
- Reset mid-frame: after 6 transfers (`LINE_W` = 4), reset, then drain 4 → exactly one `o_line_done`, after the 4th.
